// File: rtl/seq_alu.sv
// Multi-cycle ALU with START/DONE handshake: single-cycle logic/arith ops and a
// signed radix-2 Booth multiplier producing the full double-width product.
module seq_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic [OPRN_WIDTH-1:0]        OPRN,
    input  logic signed [DATA_WIDTH-1:0] OP1,
    input  logic signed [DATA_WIDTH-1:0] OP2,
    output logic                         BUSY,
    output logic                         DONE,
    output logic [DATA_WIDTH-1:0]        OUT,
    output logic [DATA_WIDTH-1:0]        OUT_HI,
    output logic                         ZERO,
    output logic                         OVF,
    output logic                         ERR
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(W - 1);
    localparam logic [W-1:0]     SHAMT_LIMIT = W'(W);

    localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
    localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
    localparam logic [OPRN_WIDTH-1:0] OP_SHR = OPRN_WIDTH'(4);
    localparam logic [OPRN_WIDTH-1:0] OP_SHL = OPRN_WIDTH'(5);
    localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6);
    localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(7);
    localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(8);
    localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(9);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic [W-1:0]            r_out;
    logic [W-1:0]            r_out_hi;
    logic                    r_zero;
    logic                    r_ovf;
    logic                    r_err;

    logic [OPRN_WIDTH-1:0]   r_oprn;
    logic signed [W-1:0]     r_op1;
    logic signed [W-1:0]     r_op2;
    logic signed [W:0]       r_acc;
    logic signed [W:0]       r_mcand;
    logic [W-1:0]            r_mq;
    logic                    r_qm1;

    logic                    w_accept;
    logic signed [W-1:0]     w_sum;
    logic signed [W-1:0]     w_diff;
    logic                    w_shift_big;
    logic [W-1:0]            w_res;
    logic                    w_ovf;
    logic                    w_err;
    logic signed [W:0]       w_acc_sum;
    logic signed [W:0]       w_acc_nxt;
    logic [W-1:0]            w_mq_nxt;
    logic                    w_qm1_nxt;
    logic                    w_mul_last;

    function automatic logic f_add_ovf(input logic a_s, input logic b_s, input logic r_s);
        return (a_s == b_s) && (r_s != a_s);
    endfunction

    function automatic logic f_sub_ovf(input logic a_s, input logic b_s, input logic r_s);
        return (a_s != b_s) && (r_s != a_s);
    endfunction

    assign w_accept    = (r_state == S_IDLE) && START;
    assign w_sum       = r_op1 + r_op2;
    assign w_diff      = r_op1 - r_op2;
    assign w_shift_big = ($unsigned(r_op2) >= SHAMT_LIMIT);

    // Single-cycle result, computed from the latched operands during EXEC.
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_err = 1'b0;
        case (r_oprn)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = f_add_ovf(r_op1[W-1], r_op2[W-1], w_sum[W-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = f_sub_ovf(r_op1[W-1], r_op2[W-1], w_diff[W-1]);
            end
            OP_MUL: w_res = '0;
            OP_SHR: w_res = w_shift_big ? '0 : ($unsigned(r_op1) >> $unsigned(r_op2));
            OP_SHL: w_res = w_shift_big ? '0 : ($unsigned(r_op1) << $unsigned(r_op2));
            OP_AND: w_res = r_op1 & r_op2;
            OP_OR:  w_res = r_op1 | r_op2;
            OP_NOR: w_res = ~(r_op1 | r_op2);
            OP_SLT: w_res = {{(W-1){1'b0}}, (r_op1 < r_op2)};
            default: w_err = 1'b1;
        endcase
    end

    // One extra accumulator bit keeps A - M exact when M is the most-negative value.
    always_comb begin
        case ({r_mq[0], r_qm1})
            2'b01:   w_acc_sum = r_acc + r_mcand;
            2'b10:   w_acc_sum = r_acc - r_mcand;
            default: w_acc_sum = r_acc;
        endcase
    end

    assign w_acc_nxt  = {w_acc_sum[W], w_acc_sum[W:1]};
    assign w_mq_nxt   = {w_acc_sum[0], r_mq[W-1:1]};
    assign w_qm1_nxt  = r_mq[0];
    assign w_mul_last = (r_cnt == CNT_LAST);

    // Operand latches and Booth shift register carry no reset: they are reloaded on every accept.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_oprn  <= OPRN;
            r_op1   <= OP1;
            r_op2   <= OP2;
            r_acc   <= '0;
            r_mcand <= {OP1[W-1], OP1};
            r_mq    <= OP2;
            r_qm1   <= 1'b0;
        end else if (r_state == S_MUL) begin
            r_acc   <= w_acc_nxt;
            r_mq    <= w_mq_nxt;
            r_qm1   <= w_qm1_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_out    <= '0;
            r_out_hi <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= (OPRN == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_out    <= w_res;
                    r_out_hi <= '0;
                    r_zero   <= (w_res == '0);
                    r_ovf    <= w_ovf;
                    r_err    <= w_err;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                S_MUL: begin
                    if (w_mul_last) begin
                        r_out    <= w_mq_nxt;
                        r_out_hi <= w_acc_nxt[W-1:0];
                        r_zero   <= (w_mq_nxt == '0);
                        r_ovf    <= 1'b0;
                        r_err    <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign OUT    = r_out;
    assign OUT_HI = r_out_hi;
    assign ZERO   = r_zero;
    assign OVF    = r_ovf;
    assign ERR    = r_err;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a 32-bit and an 8-bit instance driven with directed
// and random operations, checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_alu;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic        START32, START8;
    logic [5:0]  OPRN32, OPRN8;
    logic [31:0] A32, B32;
    logic [7:0]  A8, B8;
    logic        BUSY32, DONE32, ZERO32, OVF32, ERR32;
    logic [31:0] OUT32, OUTHI32;
    logic        BUSY8, DONE8, ZERO8, OVF8, ERR8;
    logic [7:0]  OUT8, OUTHI8;

    seq_alu #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) d32 (
        .CLK(CLK), .RST(RST), .START(START32), .OPRN(OPRN32), .OP1(A32), .OP2(B32),
        .BUSY(BUSY32), .DONE(DONE32), .OUT(OUT32), .OUT_HI(OUTHI32),
        .ZERO(ZERO32), .OVF(OVF32), .ERR(ERR32)
    );

    seq_alu #(.DATA_WIDTH(8), .OPRN_WIDTH(6)) d8 (
        .CLK(CLK), .RST(RST), .START(START8), .OPRN(OPRN8), .OP1(A8), .OP2(B8),
        .BUSY(BUSY8), .DONE(DONE8), .OUT(OUT8), .OUT_HI(OUTHI8),
        .ZERO(ZERO8), .OVF(OVF8), .ERR(ERR8)
    );

    typedef struct {
        logic [63:0] out;
        logic [63:0] hi;
        logic        zero;
        logic        ovf;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic longint sx(input logic [63:0] v, input int w);
        logic [63:0] m;
        m = v & ((64'd1 << w) - 64'd1);
        if (v[w-1]) return longint'(m) - (longint'(1) << w);
        return longint'(m);
    endfunction

    // Reference: plain integer arithmetic on sign-extended values.
    function automatic exp_t model(input int w, input int op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic [63:0] mask, ua, ub;
        longint sa, sb, p;
        mask = (64'd1 << w) - 64'd1;
        ua = a & mask;
        ub = b & mask;
        sa = sx(a, w);
        sb = sx(b, w);
        e.out = '0; e.hi = '0; e.ovf = 1'b0; e.err = 1'b0; e.acc = 0; e.lat = 0;
        case (op)
            1: begin
                e.out = 64'(sa + sb) & mask;
                e.ovf = ((sa < 0) == (sb < 0)) && (e.out[w-1] != (sa < 0));
            end
            2: begin
                e.out = 64'(sa - sb) & mask;
                e.ovf = ((sa < 0) != (sb < 0)) && (e.out[w-1] != (sa < 0));
            end
            3: begin
                p = sa * sb;
                e.out = 64'(p) & mask;
                e.hi  = 64'(p >>> w) & mask;
            end
            4: e.out = (ub >= 64'(w)) ? 64'd0 : (ua >> ub);
            5: e.out = (ub >= 64'(w)) ? 64'd0 : ((ua << ub) & mask);
            6: e.out = ua & ub;
            7: e.out = ua | ub;
            8: e.out = ~(ua | ub) & mask;
            9: e.out = (sa < sb) ? 64'd1 : 64'd0;
            default: e.err = 1'b1;
        endcase
        e.zero = (e.out == 64'd0);
        return e;
    endfunction

    always @(negedge CLK) begin : mon32
        exp_t e;
        if (RST && DONE32) begin
            if (q32.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL d32_unexpected_done: got DONE=1 at cycle %0d, expected no completion", cyc);
            end else begin
                e = q32.pop_front();
                chk("d32_out",     64'(OUT32),   e.out);
                chk("d32_out_hi",  64'(OUTHI32), e.hi);
                chk("d32_zero",    64'(ZERO32),  64'(e.zero));
                chk("d32_ovf",     64'(OVF32),   64'(e.ovf));
                chk("d32_err",     64'(ERR32),   64'(e.err));
                chk("d32_busy_at_done", 64'(BUSY32), 64'd0);
                chk("d32_latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    always @(negedge CLK) begin : mon8
        exp_t e;
        if (RST && DONE8) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL d8_unexpected_done: got DONE=1 at cycle %0d, expected no completion", cyc);
            end else begin
                e = q8.pop_front();
                chk("d8_out",     64'(OUT8),   e.out);
                chk("d8_out_hi",  64'(OUTHI8), e.hi);
                chk("d8_zero",    64'(ZERO8),  64'(e.zero));
                chk("d8_ovf",     64'(OVF8),   64'(e.ovf));
                chk("d8_err",     64'(ERR8),   64'(e.err));
                chk("d8_busy_at_done", 64'(BUSY8), 64'd0);
                chk("d8_latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    // Issue one operation, wait for completion, optionally pulsing START with junk while busy.
    task automatic go(input bit is8, input int op, input logic [63:0] a, input logic [63:0] b, input bit noise);
        exp_t e;
        int w, busy_n;
        w = is8 ? 8 : 32;
        @(negedge CLK);
        if (is8) begin
            START8 = 1'b1; OPRN8 = 6'(op); A8 = a[7:0]; B8 = b[7:0];
        end else begin
            START32 = 1'b1; OPRN32 = 6'(op); A32 = a[31:0]; B32 = b[31:0];
        end
        e = model(w, op, a, b);
        e.acc = cyc + 1;
        e.lat = (op == 3) ? w : 1;
        if (is8) q8.push_back(e); else q32.push_back(e);
        @(negedge CLK);
        START8 = 1'b0;
        START32 = 1'b0;
        busy_n = 0;
        while ((is8 ? BUSY8 : BUSY32) && busy_n < 200) begin
            busy_n++;
            if (noise) begin
                if (is8) begin
                    START8 = 1'($urandom_range(0, 1)); OPRN8 = 6'($urandom_range(0, 15));
                    A8 = 8'($urandom); B8 = 8'($urandom);
                end else begin
                    START32 = 1'($urandom_range(0, 1)); OPRN32 = 6'($urandom_range(0, 15));
                    A32 = $urandom; B32 = $urandom;
                end
            end
            @(negedge CLK);
        end
        START8 = 1'b0;
        START32 = 1'b0;
        chk(is8 ? "d8_busy_cycles" : "d32_busy_cycles", 64'(busy_n), 64'(e.lat));
    endtask

    function automatic logic [63:0] rnd_val(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return mask;
            2: return 64'd1 << (w - 1);
            3: return mask >> 1;
            4: return 64'($urandom_range(0, 40));
            default: return {32'($urandom), 32'($urandom)} & mask;
        endcase
    endfunction

    initial begin
        exp_t e;
        START32 = 1'b0; OPRN32 = '0; A32 = '0; B32 = '0;
        START8 = 1'b0;  OPRN8 = '0;  A8 = '0;  B8 = '0;
        repeat (3) @(negedge CLK);
        chk("rst_busy",   64'(BUSY32),  64'd0);
        chk("rst_done",   64'(DONE32),  64'd0);
        chk("rst_out",    64'(OUT32),   64'd0);
        chk("rst_out_hi", 64'(OUTHI32), 64'd0);
        chk("rst_zero",   64'(ZERO32),  64'd1);
        chk("rst_ovf",    64'(OVF32),   64'd0);
        chk("rst_err",    64'(ERR32),   64'd0);
        chk("rst8_zero",  64'(ZERO8),   64'd1);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        go(1'b0, 1, 64'd10, 64'd10, 1'b0);
        chk("add_out", 64'(OUT32), 64'd20);
        chk("add_zero", 64'(ZERO32), 64'd0);
        @(negedge CLK);
        chk("add_done_low", 64'(DONE32), 64'd0);

        go(1'b0, 3, 64'(-15), 64'd42, 1'b1);
        chk("mul_out", 64'(OUT32), 64'hFFFFFD8A);
        chk("mul_out_hi", 64'(OUTHI32), 64'hFFFFFFFF);

        go(1'b0, 9, 64'(-30), 64'(-30), 1'b0);
        chk("slt_eq_out", 64'(OUT32), 64'd0);
        chk("slt_eq_zero", 64'(ZERO32), 64'd1);
        go(1'b0, 4, 64'd25, 64'(-25), 1'b0);
        chk("shr_big", 64'(OUT32), 64'd0);
        go(1'b0, 5, 64'd23, 64'd0, 1'b0);
        chk("shl_zero_amt", 64'(OUT32), 64'd23);
        go(1'b0, 8, 64'(-15), 64'd42, 1'b0);
        chk("nor_out", 64'(OUT32), 64'h00000004);

        go(1'b1, 1, 64'd127, 64'd1, 1'b0);
        chk("w8_add_out", 64'(OUT8), 64'h80);
        chk("w8_add_ovf", 64'(OVF8), 64'd1);
        go(1'b1, 3, 64'h80, 64'h80, 1'b0);
        chk("w8_mul_out", 64'(OUT8), 64'h00);
        chk("w8_mul_hi", 64'(OUTHI8), 64'h40);
        chk("w8_mul_zero", 64'(ZERO8), 64'd1);

        // Illegal opcode, then an add accepted in the DONE cycle with START held high.
        @(negedge CLK);
        START32 = 1'b1; OPRN32 = 6'd12; A32 = $urandom; B32 = $urandom;
        e = model(32, 12, 64'(A32), 64'(B32)); e.acc = cyc + 1; e.lat = 1;
        q32.push_back(e);
        @(negedge CLK);
        OPRN32 = 6'd1; A32 = 32'd100; B32 = 32'hFFFFFFF6;
        e = model(32, 1, 64'(A32), 64'(B32)); e.acc = cyc + 2; e.lat = 1;
        q32.push_back(e);
        @(negedge CLK);
        chk("ill_done", 64'(DONE32), 64'd1);
        chk("ill_err", 64'(ERR32), 64'd1);
        chk("ill_out", 64'(OUT32), 64'd0);
        @(negedge CLK);
        START32 = 1'b0;
        chk("b2b_busy", 64'(BUSY32), 64'd1);
        @(negedge CLK);
        chk("b2b_done", 64'(DONE32), 64'd1);
        chk("b2b_err_clear", 64'(ERR32), 64'd0);
        chk("b2b_out", 64'(OUT32), 64'd90);

        // Reset asserted asynchronously in the middle of a multiply.
        @(negedge CLK);
        START32 = 1'b1; OPRN32 = 6'd3; A32 = 32'd12345; B32 = 32'd678;
        @(negedge CLK);
        START32 = 1'b0;
        repeat (8) @(negedge CLK);
        @(posedge CLK);
        #2 RST = 1'b0;
        q32.delete();
        #1;
        chk("arst_busy",   64'(BUSY32),  64'd0);
        chk("arst_done",   64'(DONE32),  64'd0);
        chk("arst_out",    64'(OUT32),   64'd0);
        chk("arst_out_hi", 64'(OUTHI32), 64'd0);
        chk("arst_zero",   64'(ZERO32),  64'd1);
        chk("arst_ovf",    64'(OVF32),   64'd0);
        chk("arst_err",    64'(ERR32),   64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (40) @(negedge CLK);
        go(1'b0, 1, 64'd5, 64'd7, 1'b0);
        chk("post_rst_add", 64'(OUT32), 64'd12);

        for (int i = 0; i < 40; i++)
            go(1'b0, int'($urandom_range(0, 15)), rnd_val(32), rnd_val(32), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 60; i++)
            go(1'b1, int'($urandom_range(0, 15)), rnd_val(8), rnd_val(8), 1'($urandom_range(0, 1)));

        repeat (3) @(negedge CLK);
        if (q32.size() != 0 || q8.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pending_results: got %0d/%0d outstanding, expected 0/0", q32.size(), q8.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
